// File: rtl/tlb.sv
// Fully associative MIPS-style TLB with two combinational search ports,
// one combinational read port and one synchronous write port.
module tlb #(
    parameter int TLBNUM = 16
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [18:0]                 s0_vpn2,
    input  logic                        s0_odd_page,
    input  logic [7:0]                  s0_asid,
    output logic                        s0_found,
    output logic [$clog2(TLBNUM)-1:0]   s0_index,
    output logic [19:0]                 s0_pfn,
    output logic [2:0]                  s0_c,
    output logic                        s0_d,
    output logic                        s0_v,

    input  logic [18:0]                 s1_vpn2,
    input  logic                        s1_odd_page,
    input  logic [7:0]                  s1_asid,
    output logic                        s1_found,
    output logic [$clog2(TLBNUM)-1:0]   s1_index,
    output logic [19:0]                 s1_pfn,
    output logic [2:0]                  s1_c,
    output logic                        s1_d,
    output logic                        s1_v,

    input  logic                        we,
    input  logic [$clog2(TLBNUM)-1:0]   w_index,
    input  logic [18:0]                 w_vpn2,
    input  logic [7:0]                  w_asid,
    input  logic                        w_g,
    input  logic [19:0]                 w_pfn0,
    input  logic [2:0]                  w_c0,
    input  logic                        w_d0,
    input  logic                        w_v0,
    input  logic [19:0]                 w_pfn1,
    input  logic [2:0]                  w_c1,
    input  logic                        w_d1,
    input  logic                        w_v1,

    input  logic [$clog2(TLBNUM)-1:0]   r_index,
    output logic [18:0]                 r_vpn2,
    output logic [7:0]                  r_asid,
    output logic                        r_g,
    output logic [19:0]                 r_pfn0,
    output logic [2:0]                  r_c0,
    output logic                        r_d0,
    output logic                        r_v0,
    output logic [19:0]                 r_pfn1,
    output logic [2:0]                  r_c1,
    output logic                        r_d1,
    output logic                        r_v1
);

    localparam int IW = $clog2(TLBNUM);

    logic [TLBNUM-1:0] used;
    logic [TLBNUM-1:0] g;
    logic [18:0]       tlb_vpn2 [TLBNUM];
    logic [7:0]        tlb_asid [TLBNUM];
    logic [19:0]       tlb_pfn0 [TLBNUM];
    logic [19:0]       tlb_pfn1 [TLBNUM];
    logic [2:0]        tlb_c0   [TLBNUM];
    logic [2:0]        tlb_c1   [TLBNUM];
    logic [TLBNUM-1:0] d0, v0, d1, v1;

    logic [TLBNUM-1:0] match0, match1;
    logic [IW-1:0]     hit0, hit1;

    // Reset wins over a concurrent write, so that entry stays cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            used <= '0;
            g    <= '0;
            d0   <= '0;
            v0   <= '0;
            d1   <= '0;
            v1   <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_vpn2[i] <= '0;
                tlb_asid[i] <= '0;
                tlb_pfn0[i] <= '0;
                tlb_pfn1[i] <= '0;
                tlb_c0[i]   <= '0;
                tlb_c1[i]   <= '0;
            end
        end else if (we) begin
            used[w_index]     <= 1'b1;
            g[w_index]        <= w_g;
            tlb_vpn2[w_index] <= w_vpn2;
            tlb_asid[w_index] <= w_asid;
            tlb_pfn0[w_index] <= w_pfn0;
            tlb_c0[w_index]   <= w_c0;
            d0[w_index]       <= w_d0;
            v0[w_index]       <= w_v0;
            tlb_pfn1[w_index] <= w_pfn1;
            tlb_c1[w_index]   <= w_c1;
            d1[w_index]       <= w_d1;
            v1[w_index]       <= w_v1;
        end
    end

    // Descending scan leaves the lowest-numbered matching entry in hit0/hit1.
    always_comb begin
        match0 = '0;
        match1 = '0;
        hit0   = '0;
        hit1   = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match0[i] = used[i] && (tlb_vpn2[i] == s0_vpn2) && (g[i] || (tlb_asid[i] == s0_asid));
            match1[i] = used[i] && (tlb_vpn2[i] == s1_vpn2) && (g[i] || (tlb_asid[i] == s1_asid));
        end
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match0[i]) hit0 = i[IW-1:0];
            if (match1[i]) hit1 = i[IW-1:0];
        end
    end

    always_comb begin
        s0_found = |match0;
        s0_index = hit0;
        s0_pfn   = '0;
        s0_c     = '0;
        s0_d     = 1'b0;
        s0_v     = 1'b0;
        if (s0_found) begin
            s0_pfn = s0_odd_page ? tlb_pfn1[hit0] : tlb_pfn0[hit0];
            s0_c   = s0_odd_page ? tlb_c1[hit0]   : tlb_c0[hit0];
            s0_d   = s0_odd_page ? d1[hit0]       : d0[hit0];
            s0_v   = s0_odd_page ? v1[hit0]       : v0[hit0];
        end
    end

    always_comb begin
        s1_found = |match1;
        s1_index = hit1;
        s1_pfn   = '0;
        s1_c     = '0;
        s1_d     = 1'b0;
        s1_v     = 1'b0;
        if (s1_found) begin
            s1_pfn = s1_odd_page ? tlb_pfn1[hit1] : tlb_pfn0[hit1];
            s1_c   = s1_odd_page ? tlb_c1[hit1]   : tlb_c0[hit1];
            s1_d   = s1_odd_page ? d1[hit1]       : d0[hit1];
            s1_v   = s1_odd_page ? v1[hit1]       : v0[hit1];
        end
    end

    assign r_vpn2 = tlb_vpn2[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_g    = g[r_index];
    assign r_pfn0 = tlb_pfn0[r_index];
    assign r_c0   = tlb_c0[r_index];
    assign r_d0   = d0[r_index];
    assign r_v0   = v0[r_index];
    assign r_pfn1 = tlb_pfn1[r_index];
    assign r_c1   = tlb_c1[r_index];
    assign r_d1   = d1[r_index];
    assign r_v1   = v1[r_index];

endmodule

// File: tb/tb_tlb.sv
// Directed self-checking bench for tlb: search expectations go through a
// scoreboard queue, read-port and reset checks compare against constants.
module tb_tlb;

    logic        clk = 1'b0;
    logic        reset;

    logic [18:0] s0_vpn2, s1_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s0_v, s1_d, s1_v;

    logic        we;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        w_d0, w_v0, w_d1, w_v1;

    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;

    typedef struct {
        logic        found;
        logic [3:0]  index;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    tlb #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_write(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                               input logic gbit,
                               input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                               input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = gbit;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
        we = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                            input logic gbit,
                            input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                            input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        drive_write(idx, vpn2, asid, gbit, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    // Drive one search port and queue the result the bench expects from it.
    task automatic applyStimulus(input int port, input logic [18:0] vpn2, input logic odd,
                                 input logic [7:0] asid, input logic found, input logic [3:0] index,
                                 input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v);
        exp_t e;
        e.found = found; e.index = index; e.pfn = pfn; e.c = c; e.d = d; e.v = v;
        sb.push_back(e);
        if (port == 0) begin
            s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
        end else begin
            s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
        end
    endtask

    task automatic checkOutput(input int port);
        exp_t e;
        logic        f, d, v;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (port == 0) begin
            f = s0_found; idx = s0_index; pfn = s0_pfn; c = s0_c; d = s0_d; v = s0_v;
        end else begin
            f = s1_found; idx = s1_index; pfn = s1_pfn; c = s1_c; d = s1_d; v = s1_v;
        end
        check($sformatf("s%0d_found", port), {127'd0, f}, {127'd0, e.found});
        check($sformatf("s%0d_index", port), {124'd0, idx}, {124'd0, e.index});
        check($sformatf("s%0d_pfn", port), {108'd0, pfn}, {108'd0, e.pfn});
        check($sformatf("s%0d_cdv", port), {123'd0, c, d, v}, {123'd0, e.c, e.d, e.v});
    endtask

    function automatic logic [127:0] read_bus();
        return {50'd0, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
    endfunction

    initial begin
        reset = 1'b1; we = 1'b0; r_index = '0;
        w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Empty TLB: both ports miss, read port is all zero.
        applyStimulus(0, 19'h0, 1'b0, 8'h00, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        checkOutput(0);
        applyStimulus(1, 19'h0, 1'b0, 8'h00, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        checkOutput(1);
        r_index = 4'd0;
        #1 check("reset_read0", read_bus(), 128'd0);

        // ASID-private entry at index 3.
        do_write(4'd3, 19'h12345, 8'h05, 1'b0, 20'h00ABC, 3'd0, 1'b0, 1'b1, 20'h00DEF, 3'd0, 1'b1, 1'b1);
        applyStimulus(0, 19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'h00DEF, 3'd0, 1'b1, 1'b1);
        checkOutput(0);
        applyStimulus(0, 19'h12345, 1'b0, 8'h05, 1'b1, 4'd3, 20'h00ABC, 3'd0, 1'b0, 1'b1);
        checkOutput(0);
        applyStimulus(0, 19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        checkOutput(0);

        // Global entry at index 7 hits under any ASID; odd page has v=0 but still hits.
        do_write(4'd7, 19'h0ABCD, 8'h00, 1'b1, 20'h11111, 3'd3, 1'b0, 1'b1, 20'h22222, 3'd5, 1'b1, 1'b0);
        applyStimulus(1, 19'h0ABCD, 1'b0, 8'h77, 1'b1, 4'd7, 20'h11111, 3'd3, 1'b0, 1'b1);
        checkOutput(1);
        applyStimulus(1, 19'h0ABCD, 1'b1, 8'hFF, 1'b1, 4'd7, 20'h22222, 3'd5, 1'b1, 1'b0);
        checkOutput(1);
        r_index = 4'd7;
        #1 check("read7", read_bus(),
                 {50'd0, 19'h0ABCD, 8'h00, 1'b1, 20'h11111, 3'd3, 1'b0, 1'b1, 20'h22222, 3'd5, 1'b1, 1'b0});

        // Duplicate tags at 2 and 9: lowest index wins until 2 is retagged.
        do_write(4'd9, 19'h55555, 8'h21, 1'b0, 20'h00900, 3'd1, 1'b0, 1'b1, 20'h00901, 3'd1, 1'b0, 1'b1);
        do_write(4'd2, 19'h55555, 8'h21, 1'b0, 20'h00200, 3'd2, 1'b1, 1'b1, 20'h00201, 3'd2, 1'b0, 1'b1);
        applyStimulus(0, 19'h55555, 1'b0, 8'h21, 1'b1, 4'd2, 20'h00200, 3'd2, 1'b1, 1'b1);
        checkOutput(0);
        do_write(4'd2, 19'h55556, 8'h21, 1'b0, 20'h00200, 3'd2, 1'b1, 1'b1, 20'h00201, 3'd2, 1'b0, 1'b1);
        applyStimulus(0, 19'h55555, 1'b0, 8'h21, 1'b1, 4'd9, 20'h00900, 3'd1, 1'b0, 1'b1);
        checkOutput(0);

        // Write to 4 is invisible to a same-cycle search and the read port.
        r_index = 4'd4;
        drive_write(4'd4, 19'h44444, 8'h44, 1'b0, 20'h04040, 3'd4, 1'b0, 1'b1, 20'h04041, 3'd4, 1'b1, 1'b1);
        applyStimulus(1, 19'h44444, 1'b0, 8'h44, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        checkOutput(1);
        check("read4_before", read_bus(), 128'd0);
        @(posedge clk);
        #1 we = 1'b0;
        applyStimulus(1, 19'h44444, 1'b0, 8'h44, 1'b1, 4'd4, 20'h04040, 3'd4, 1'b0, 1'b1);
        checkOutput(1);
        check("read4_after_vpn2", {109'd0, r_vpn2}, {109'd0, 19'h44444});

        // Both ports hitting different entries at once.
        applyStimulus(0, 19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'h00DEF, 3'd0, 1'b1, 1'b1);
        applyStimulus(1, 19'h44444, 1'b1, 8'h44, 1'b1, 4'd4, 20'h04041, 3'd4, 1'b1, 1'b1);
        checkOutput(0);
        checkOutput(1);

        // Fill all 16 entries, then reset with a write pending on entry 5.
        for (int i = 0; i < 16; i++)
            do_write(i[3:0], 19'h00100 + 19'(i), 8'h01, 1'b0, 20'h01000 + 20'(i), i[2:0], 1'b0, 1'b1,
                     20'h02000 + 20'(i), 3'd0, 1'b1, 1'b1);
        applyStimulus(0, 19'h00105, 1'b0, 8'h01, 1'b1, 4'd5, 20'h01005, 3'd5, 1'b0, 1'b1);
        checkOutput(0);
        reset = 1'b1;
        drive_write(4'd5, 19'h00105, 8'h01, 1'b0, 20'h0AAAA, 3'd7, 1'b1, 1'b1, 20'h0BBBB, 3'd7, 1'b1, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0; we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 19'h00100 + 19'(i), 1'b0, 8'h01, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
            checkOutput(0);
            r_index = i[3:0];
            #1 check($sformatf("post_reset_read%0d", i), read_bus(), 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
